// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared register map, control/status bit indices and sequencer states for spm_wb_ctrl
package spm_pkg;

   localparam logic [2:0] REG_MC      = 3'd0;
   localparam logic [2:0] REG_MP      = 3'd1;
   localparam logic [2:0] REG_CTRL    = 3'd2;
   localparam logic [2:0] REG_STATUS  = 3'd3;
   localparam logic [2:0] REG_PROD_LO = 3'd4;
   localparam logic [2:0] REG_PROD_HI = 3'd5;

   localparam int CTRL_GO   = 0;
   localparam int CTRL_IE   = 1;
   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_TMO  = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      WAIT   = 3'd2,
      CAP_LO = 3'd3,
      CAP_HI = 3'd4
   } spm_state_t;

endpackage

// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - launch/wait/capture sequencer for the SPM multiplier with done timeout
module spm_seq
   import spm_pkg::*;
#(
   parameter int TMO_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_go,
   input  logic        i_done,
   input  logic [31:0] i_prod,
   output logic        o_start,
   output logic        o_prod_sel,
   output logic        o_busy,
   output logic        o_set_done,
   output logic        o_set_tmo,
   output logic [31:0] o_prod_lo,
   output logic [31:0] o_prod_hi
);

   // Last WAIT cycle is the one where the count would reach 2**TMO_W-1.
   localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

   spm_state_t       r_state;
   logic [TMO_W-1:0] r_cnt;
   logic [31:0]      r_prod_lo;
   logic [31:0]      r_prod_hi;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_prod_lo <= '0;
         r_prod_hi <= '0;
      end else begin
         case (r_state)
            IDLE:   if (i_go) r_state <= START;
            START: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (i_done)                r_state <= CAP_LO;
               else if (r_cnt == TMO_LAST) r_state <= IDLE;
               else                       r_cnt   <= r_cnt + TMO_W'(1);
            end
            CAP_LO: begin
               r_prod_lo <= i_prod;
               r_state   <= CAP_HI;
            end
            // prod_sel is high for this whole cycle, so the high half has settled by the edge.
            CAP_HI: begin
               r_prod_hi <= i_prod;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_start    = (r_state == START);
   assign o_prod_sel = (r_state == CAP_HI);
   assign o_busy     = (r_state != IDLE);
   assign o_set_done = (r_state == CAP_HI);
   assign o_set_tmo  = (r_state == WAIT) & ~i_done & (r_cnt == TMO_LAST);
   assign o_prod_lo  = r_prod_lo;
   assign o_prod_hi  = r_prod_hi;

endmodule

// File: rtl/spm_wb_ctrl.sv
// rtl/spm_wb_ctrl.sv - Wishbone slave front end for the SPM multiplier; SPM_IRQ_EN adds CTRL.IE and irq
module spm_wb_ctrl
   import spm_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          TMO_W     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic [31:0] mc,
   output logic [31:0] mp,
   output logic        start,
   output logic        prod_sel,
   input  logic        done,
   input  logic [31:0] prod,
   output logic        irq
);

   logic        r_ack;
   logic [31:0] r_dat;
   logic [31:0] r_mc;
   logic [31:0] r_mp;
   logic        r_done;
   logic        r_tmo;

   logic        w_hit, w_req, w_wr, w_busy, w_go, w_ie;
   logic        w_w1c_done, w_w1c_tmo, w_set_done, w_set_tmo;
   logic [2:0]  w_idx;
   logic [31:0] w_rdata, w_prod_lo, w_prod_hi;
   logic        w_unused;

   assign w_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // Masking with r_ack gives one ack per transfer even when stb stays high.
   assign w_req = w_hit & ~r_ack;
   assign w_wr  = w_req & wbs_we_i;
   assign w_idx = wbs_adr_i[4:2];

   assign w_go       = w_wr & (w_idx == REG_CTRL) & wbs_sel_i[0] & wbs_dat_i[CTRL_GO] & ~w_busy;
   assign w_w1c_done = w_wr & (w_idx == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_DONE];
   assign w_w1c_tmo  = w_wr & (w_idx == REG_STATUS) & wbs_sel_i[0] & wbs_dat_i[STAT_TMO];
   assign w_unused   = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         REG_MC:      w_rdata = r_mc;
         REG_MP:      w_rdata = r_mp;
         REG_CTRL:    w_rdata[CTRL_IE] = w_ie;
         REG_STATUS: begin
            w_rdata[STAT_BUSY] = w_busy;
            w_rdata[STAT_DONE] = r_done;
            w_rdata[STAT_TMO]  = r_tmo;
         end
         REG_PROD_LO: w_rdata = w_prod_lo;
         REG_PROD_HI: w_rdata = w_prod_hi;
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack  <= 1'b0;
         r_dat  <= '0;
         r_mc   <= '0;
         r_mp   <= '0;
         r_done <= 1'b0;
         r_tmo  <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req & ~wbs_we_i) ? w_rdata : '0;
         for (int i = 0; i < 4; i++) begin
            if (w_wr & ~w_busy & wbs_sel_i[i]) begin
               if (w_idx == REG_MC) r_mc[i*8 +: 8] <= wbs_dat_i[i*8 +: 8];
               if (w_idx == REG_MP) r_mp[i*8 +: 8] <= wbs_dat_i[i*8 +: 8];
            end
         end
         if (w_set_done)                  r_done <= 1'b1;
         else if (w_go | w_w1c_done)      r_done <= 1'b0;
         if (w_set_tmo)                   r_tmo  <= 1'b1;
         else if (w_go | w_w1c_tmo)       r_tmo  <= 1'b0;
      end
   end

`ifdef SPM_IRQ_EN
   logic r_ie;
   logic r_irq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ie  <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         if (w_wr & (w_idx == REG_CTRL) & wbs_sel_i[0]) r_ie <= wbs_dat_i[CTRL_IE];
         r_irq <= r_ie & (r_done | r_tmo);
      end
   end

   assign w_ie = r_ie;
   assign irq  = r_irq;
`else
   assign w_ie = 1'b0;
   assign irq  = 1'b0;
`endif

   spm_seq #(.TMO_W(TMO_W)) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_go       (w_go),
      .i_done     (done),
      .i_prod     (prod),
      .o_start    (start),
      .o_prod_sel (prod_sel),
      .o_busy     (w_busy),
      .o_set_done (w_set_done),
      .o_set_tmo  (w_set_tmo),
      .o_prod_lo  (w_prod_lo),
      .o_prod_hi  (w_prod_hi)
   );

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign mc        = r_mc;
   assign mp        = r_mp;

endmodule
